// File: rtl/cur_chroma_load_ctrl_if.sv
// cur_chroma_load_ctrl_if: bus read channel plus chroma buffer ext_load write port.
interface cur_chroma_load_ctrl_if #(parameter int DATA_W = 256, parameter int ADDR_W = 6);
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic              ext_load_valid;
  logic [ADDR_W-1:0] ext_load_addr;
  logic [DATA_W-1:0] ext_load_data;
  logic              ext_load_done;
  modport slave (
    input  bus_data, bus_valid,
    output bus_ready, ext_load_valid, ext_load_addr, ext_load_data, ext_load_done
  );
  modport master (
    output bus_data, bus_valid,
    input  bus_ready, ext_load_valid, ext_load_addr, ext_load_data, ext_load_done
  );
endinterface

// File: rtl/cur_chroma_load_ctrl.sv
// cur_chroma_load_ctrl: sequences one LCU chroma load into the triple buffer.
// Optional load cycle counter output under CUR_CHROMA_LOAD_CYC_EN.
module cur_chroma_load_ctrl #(
  parameter int DATA_W     = 256,
  parameter int LOAD_WORDS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sysif_start_i,
  cur_chroma_load_ctrl_if.slave bus,
  output logic       load_busy_o,
  output logic [1:0] rotate_o,
`ifdef CUR_CHROMA_LOAD_CYC_EN
  output logic [15:0] load_cycles_o,
`endif
  output logic       overrun_o
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(LOAD_WORDS - 1);
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_cnt;
  logic [1:0]        r_rot;
  logic              r_ovr, r_valid, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_load, w_acc, w_last, w_abort;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_load  = r_state == LOAD;
    w_acc   = bus.bus_valid && w_load;
    w_last  = w_acc && r_cnt == LAST;
    w_abort = sysif_start_i && w_load && !w_last;
    w_next  = (sysif_start_i || (w_load && !w_last)) ? LOAD : w_last ? DONE : IDLE;
  end
  // a start aborting a load also discards any beat accepted alongside it
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_cnt   <= '0;
      r_rot   <= '0;
      r_ovr   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_cnt   <= sysif_start_i ? '0 : r_cnt + (ADDR_W+1)'(w_acc);
      r_rot   <= sysif_start_i ? (r_rot == 2'd2 ? 2'd0 : r_rot + 2'd1) : r_rot;
      r_ovr   <= r_ovr | w_abort;
      r_valid <= w_acc && !w_abort;
      r_done  <= w_last;
      if (w_acc && !w_abort) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= bus.bus_data;
      end
    end
`ifdef CUR_CHROMA_LOAD_CYC_EN
  logic [15:0] r_cyc, r_cyc_q, w_cyc_inc;
  assign w_cyc_inc = r_cyc == 16'hFFFF ? r_cyc : r_cyc + 16'd1;
  // latch on the final beat so the value is valid together with done
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_cyc   <= '0;
      r_cyc_q <= '0;
    end else begin
      r_cyc <= sysif_start_i ? 16'd0 : w_load ? w_cyc_inc : r_cyc;
      if (w_last) r_cyc_q <= w_cyc_inc;
    end
  assign load_cycles_o = r_cyc_q;
`endif
  assign bus.bus_ready      = w_load;
  assign bus.ext_load_valid = r_valid;
  assign bus.ext_load_addr  = r_addr;
  assign bus.ext_load_data  = r_data;
  assign bus.ext_load_done  = r_done;
  assign load_busy_o        = w_load;
  assign rotate_o           = r_rot;
  assign overrun_o          = r_ovr;
endmodule

// File: tb/tb_cur_chroma_load_ctrl.sv
// tb_cur_chroma_load_ctrl: directed self-checking bench for cur_chroma_load_ctrl.
module tb_cur_chroma_load_ctrl;
  logic clk = 0, rstn = 0, start = 0;
  logic [1:0] rotate;
  logic busy, ovr;
  int total = 0, bad = 0, exp_rot = 0, ndone;
`ifdef CUR_CHROMA_LOAD_CYC_EN
  logic [15:0] cyc;
`endif
  cur_chroma_load_ctrl_if #(.DATA_W(256), .ADDR_W(6)) bus();
  cur_chroma_load_ctrl #(.DATA_W(256), .LOAD_WORDS(64), .ADDR_W(6)) dut (
    .clk(clk), .rstn(rstn), .sysif_start_i(start), .bus(bus),
    .load_busy_o(busy), .rotate_o(rotate),
`ifdef CUR_CHROMA_LOAD_CYC_EN
    .load_cycles_o(cyc),
`endif
    .overrun_o(ovr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic s, input logic v, input logic [255:0] d);
    start = s;
    bus.bus_valid = v;
    bus.bus_data = d;
    if (s) exp_rot = (exp_rot + 1) % 3;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input string tag, input int a, input logic [255:0] d, input logic dn);
    chk({tag, "_v"}, bus.ext_load_valid, 1);
    chk({tag, "_a"}, bus.ext_load_addr, a);
    chk({tag, "_d"}, bus.ext_load_data, d);
    chk({tag, "_dn"}, bus.ext_load_done, dn);
  endtask
  task automatic full_load(input string tag);
    step(1, 0, 0);
    chk({tag, "_rot"}, rotate, exp_rot);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 256'(i + 1000));
      wr(tag, i, 256'(i + 1000), i == 63);
    end
    chk({tag, "_rdy"}, bus.bus_ready, 0);
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, "_v"}, bus.ext_load_valid, 0);
    chk({tag, "_a"}, bus.ext_load_addr, 0);
    chk({tag, "_d"}, bus.ext_load_data, 0);
    chk({tag, "_dn"}, bus.ext_load_done, 0);
    chk({tag, "_rdy"}, bus.bus_ready, 0);
    chk({tag, "_bsy"}, busy, 0);
    chk({tag, "_rot"}, rotate, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask
  initial begin
    bus.bus_valid = 0;
    bus.bus_data = 0;
    repeat (3) @(posedge clk);
    #1;
    idle_outs("rst");
    rstn = 1;
    step(1, 0, 0);
    chk("t1_rdy", bus.bus_ready, 1);
    chk("t1_bsy", busy, 1);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 256'(i));
      wr("t1", i, 256'(i), i == 63);
    end
    chk("t1_rot", rotate, 1);
    chk("t1_ovr", ovr, 0);
    chk("t1_rdy_end", bus.bus_ready, 0);
    step(0, 0, 0);
    chk("t1_v_off", bus.ext_load_valid, 0);
    chk("t1_hold_a", bus.ext_load_addr, 63);
    chk("t1_dn_off", bus.ext_load_done, 0);
    step(1, 0, 0);
    chk("t2_rot", rotate, 2);
    ndone = 0;
    for (int c = 0; c < 127; c++) begin
      chk("t2_rdy", bus.bus_ready, 1);
      step(0, c % 2 == 0, 256'(c + 7));
      ndone += int'(bus.ext_load_done);
      if (c % 2 == 0) wr("t2", c / 2, 256'(c + 7), c == 126);
      else chk("t2_gap", bus.ext_load_valid, 0);
    end
    chk("t2_ndone", ndone, 1);
    chk("t2_rdy_end", bus.bus_ready, 0);
    step(1, 0, 0);
    for (int i = 0; i < 63; i++) step(0, 1, 256'(i + 300));
    chk("t4_a62", bus.ext_load_addr, 62);
    step(1, 1, 777);
    wr("t4_last", 63, 777, 1);
    chk("t4_ovr", ovr, 0);
    chk("t4_rdy", bus.bus_ready, 1);
    step(0, 1, 55);
    wr("t4_next", 0, 55, 0);
    for (int i = 1; i < 64; i++) step(0, 1, 256'(i));
    chk("t4_done", bus.ext_load_done, 1);
    chk("t4_rot", rotate, exp_rot);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 256'(i + 100));
    chk("t3_a19", bus.ext_load_addr, 19);
    step(1, 1, 999);
    chk("t3_drop", bus.ext_load_valid, 0);
    chk("t3_nodn", bus.ext_load_done, 0);
    chk("t3_ovr", ovr, 1);
    chk("t3_rot", rotate, exp_rot);
    step(0, 1, 500);
    wr("t3_re", 0, 500, 0);
    for (int i = 1; i < 64; i++) begin
      step(0, 1, 256'(i + 500));
      wr("t3_rest", i, 256'(i + 500), i == 63);
    end
    chk("t3_ovr_sticky", ovr, 1);
    full_load("t5a");
    chk("t5_rot1", rotate, 1);
    full_load("t5b");
    chk("t5_rot2", rotate, 2);
    full_load("t5c");
    chk("t5_rot0", rotate, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 256'(i + 1));
    chk("t6_pre_v", bus.ext_load_valid, 1);
    #2 rstn = 0;
    #1;
    exp_rot = 0;
    idle_outs("t6_async");
    @(posedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 256'(i + 40));
      chk("t6_nowr", bus.ext_load_valid, 0);
      chk("t6_rdy", bus.bus_ready, 0);
    end
`ifdef CUR_CHROMA_LOAD_CYC_EN
    step(1, 0, 0);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0);
      step(0, 1, 256'(i));
    end
    chk("t7_dn", bus.ext_load_done, 1);
    chk("t7_cyc", cyc, 128);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cur_chroma_load_ctrl.md
Name: cur_chroma_load_ctrl

Overview:
- Sequences the external load of one LCU's chroma pixels into the current-LCU chroma triple buffer.
- Sits between the system bus read channel and the buffer's ext_load_* write port.
- On each sysif_start_i it accepts exactly LOAD_WORDS bus beats and generates registered write strobes with linear addresses, then pulses a done signal.
- Tracks the buffer rotation index in lockstep with the buffer and flags loads cut short by a new start.

Parameters:
- DATA_W, 256, width of one load word (32 pixels x PIXEL_WIDTH 8).
- LOAD_WORDS, 64, beats per LCU chroma load (U+V of 32x32 each, 4:2:0); must be <= 64.
- ADDR_W, 6, buffer word address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- sysif_start_i  in  1  LCU start pulse; the same signal that rotates the triple buffer.
- bus_data_i  in  DATA_W  bus read data.
- bus_valid_i  in  1  bus data valid.
- bus_ready_o  out  1  controller accepts a beat.
- ext_load_valid_o  out  1  buffer write enable.
- ext_load_addr_o  out  ADDR_W  buffer write address.
- ext_load_data_o  out  DATA_W  buffer write data.
- ext_load_done_o  out  1  one-cycle pulse when the load is complete.
- load_busy_o  out  1  high while in LOAD.
- rotate_o  out  2  rotation index 0..2, mirrors the buffer.
- overrun_o  out  1  sticky: a start arrived before the previous load completed.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; rotate_o 0.
- States are IDLE, LOAD and DONE; DONE lasts one cycle.
  - IDLE: sysif_start_i goes to LOAD with counter=0.
  - LOAD: every beat handshake increments the counter. The beat with counter==LOAD_WORDS-1 goes to DONE.
  - DONE: ext_load_done_o=1 for this cycle. Returns to IDLE, or to LOAD if sysif_start_i is high in that cycle.
- Handshake:
  - bus_ready_o = (state==LOAD). It is combinational from state only and never depends on bus_valid_i.
  - A beat is accepted when bus_valid_i && bus_ready_o.
- Write latency is 1 cycle after acceptance:
  - ext_load_valid_o=1.
  - ext_load_addr_o = counter value at acceptance.
  - ext_load_data_o = accepted data.
  - When ext_load_valid_o=0, ext_load_addr_o and ext_load_data_o hold their last values.
- Bubbles: gaps in bus_valid_i produce gaps in ext_load_valid_o. Addresses stay strictly consecutive, 0..LOAD_WORDS-1.
- Done timing: ext_load_done_o is asserted in the same cycle as the final ext_load_valid_o, i.e. the cycle after the last accepted beat.
- rotate_o advances on every sysif_start_i, wrapping 2 -> 0, regardless of state.
- Start during LOAD with the final beat not accepted that cycle:
  - Set overrun_o.
  - Abort the load: no done pulse.
  - Reset counter to 0 and stay in LOAD for the new LCU.
  - A beat accepted in that same cycle is dropped: no write is issued.
- Start in the same cycle as the final beat: the load counts as complete, so no overrun.
  - The final write and done pulse occur next cycle as normal.
  - The next state is LOAD with counter 0 (this overrides DONE).
- Start in DONE: done still pulses; go to LOAD.
- overrun_o clears only on reset.
- Counter width is ADDR_W+1 so the count never wraps before the final compare.

Optional Feature:
- Macro: CUR_CHROMA_LOAD_CYC_EN.
- With the macro defined, add output load_cycles_o, 16 bits:
  - An internal counter clears on entry to LOAD and increments every LOAD cycle, saturating at 16'hFFFF.
  - load_cycles_o latches the counter when ext_load_done_o fires and holds until the next completed load.
  - Reset value 0.
- Without the macro: no port and no counter logic.

Test Plan:
- Reset, then start, then 64 back-to-back beats with data = beat index:
  - ext_load_valid_o is high for 64 cycles with addr 0..63 and data 0..63.
  - done pulses with addr 63.
  - rotate_o=1; overrun_o=0.
- Start with a valid pattern of 1 on, 1 off:
  - Addresses remain consecutive 0..63 across 127 bus cycles.
  - Exactly one done pulse; bus_ready_o drops the cycle after the 64th accepted beat.
- Start, 20 beats, then a second start:
  - overrun_o=1 and stays 1.
  - No done pulse for the first load.
  - The next write uses addr 0; a beat coinciding with the start is not written.
- Start coinciding with the 64th beat:
  - The write to addr 63 and done occur next cycle; overrun_o=0.
  - The following beat is written to addr 0.
- Three starts with full loads:
  - rotate_o sequence 1, 2, 0.
  - Assert rstn low mid-load: all outputs 0 immediately and state IDLE; no write after release until the next start.
- With CUR_CHROMA_LOAD_CYC_EN, 64 beats with 1 idle cycle before each: load_cycles_o=128 after done.
